// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential imem requests and buffers {pc, inst} for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue holds no filled entry.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0,
   parameter logic [15:0] NOP_INST = 16'h1000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [15:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [15:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [15:0] dec_inst,
   output logic [15:0] dec_pc,
   output logic [15:0] dec_pc_plus1
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [15:0]      fetch_pc;
   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    alloc_ptr;
   logic [PW-1:0]    fill_ptr;
   logic [CW-1:0]    alloc_cnt;
   logic [CW-1:0]    pend_cnt;
   logic [CW-1:0]    drop_cnt;
   logic [15:0]      slot_pc   [DEPTH];
   logic [15:0]      slot_inst [DEPTH];
   logic [DEPTH-1:0] slot_valid;
   logic [DEPTH-1:0] valid_nxt;

   logic head_valid;
   logic can_fill;
   logic byp;
   logic byp_take;
   logic req_fire;
   logic deq;
   logic no_drop;

   assign no_drop    = (drop_cnt == '0);
   assign head_valid = slot_valid[head_ptr];
   assign can_fill   = !rst & imem_rsp_valid & no_drop & !redirect_valid;

`ifdef FETCH_BYPASS_EN
   // Head slot is the oldest unfilled one whenever nothing is filled yet.
   assign byp = can_fill & !head_valid;
`else
   assign byp = 1'b0;
`endif

   assign imem_req_valid = !rst & !halt & !redirect_valid & no_drop
                         & (alloc_cnt < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign dec_valid    = (head_valid | byp) & !redirect_valid;
   assign dec_pc       = slot_pc[head_ptr];
   assign dec_pc_plus1 = dec_pc + 16'd1;
   assign deq          = dec_valid & dec_ready;
   assign byp_take     = byp & deq;

   always_comb begin
      dec_inst = NOP_INST;
      if (dec_valid) begin
         dec_inst = head_valid ? slot_inst[head_ptr] : imem_rsp_data;
      end
   end

   always_comb begin
      valid_nxt = slot_valid;
      if (deq && head_valid) begin
         valid_nxt[head_ptr] = 1'b0;
      end
      if (can_fill && !byp_take) begin
         valid_nxt[fill_ptr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         head_ptr   <= '0;
         alloc_ptr  <= '0;
         fill_ptr   <= '0;
         alloc_cnt  <= '0;
         pend_cnt   <= '0;
         drop_cnt   <= '0;
         slot_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc[i]   <= '0;
            slot_inst[i] <= '0;
         end
      end else if (redirect_valid) begin
         // Everything still in flight, minus a response landing now, must be discarded.
         fetch_pc   <= redirect_pc;
         head_ptr   <= '0;
         alloc_ptr  <= '0;
         fill_ptr   <= '0;
         alloc_cnt  <= '0;
         pend_cnt   <= '0;
         slot_valid <= '0;
         drop_cnt   <= drop_cnt + pend_cnt - CW'(imem_rsp_valid);
      end else begin
         slot_valid <= valid_nxt;
         alloc_cnt  <= alloc_cnt + CW'(req_fire) - CW'(deq);
         pend_cnt   <= pend_cnt + CW'(req_fire) - CW'(can_fill);
         if (req_fire) begin
            slot_pc[alloc_ptr] <= fetch_pc;
            alloc_ptr          <= alloc_ptr + PW'(1);
            fetch_pc           <= fetch_pc + 16'd1;
         end
         if (can_fill) begin
            slot_inst[fill_ptr] <= imem_rsp_data;
            fill_ptr            <= fill_ptr + PW'(1);
         end
         if (deq) begin
            head_ptr <= head_ptr + PW'(1);
         end
         if (imem_rsp_valid && !no_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

endmodule
